qrst_arbiter: RTL and testbench



---
 rtl/qrst_arb_pkg.sv | 23 ++
 rtl/qrst_arbiter_rr_arbiter.sv | 46 ++++
 rtl/qrst_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_qrst_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/qrst_arb_pkg.sv
// Shared types and constants for the QICK reset/sync command arbiter.
package qrst_arb_pkg;

  // Arbiter FSM states, sequentially encoded.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StRun  = 3'd2,
    StRel  = 3'd3,
    StDone = 3'd4,
    StErr  = 3'd5
  } state_e;

  // Request type latched at grant time.
  localparam logic TYPE_QRST  = 1'b0;
  localparam logic TYPE_QSYNC = 1'b1;

  // True in the states where the arbiter is waiting on the engine.
  function automatic logic is_engine_wait(state_e s);
    return (s == StReq) || (s == StRun) || (s == StRel);
  endfunction

endpackage

// File: rtl/qrst_arbiter_rr_arbiter.sv
// Round-robin picker with its own pointer register. The pick is combinational:
// first set request at or after the pointer, wrapping. On load the pointer
// moves to one past the picked index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    load_i,
  output logic                    gnt_valid_o,
  output logic [$clog2(NREQ)-1:0] gnt_id_o
);

  localparam int unsigned IdW = $clog2(NREQ);

  logic [IdW-1:0] ptr_q;

  // Scan requests starting at the pointer, wrapping around once.
  always_comb begin
    int unsigned idx;
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!gnt_valid_o && req_i[IdW'(idx)]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = IdW'(idx);
      end
    end
  end

  // Advance the pointer past the winner when the grant is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (load_i && gnt_valid_o) begin
      ptr_q <= (gnt_id_o == IdW'(NREQ - 1)) ? '0 : gnt_id_o + 1'b1;
    end
  end

endmodule

// File: rtl/qrst_arbiter.sv
// Arbitrates the single QICK reset/sync engine between NREQ requesters.
// Grants round-robin, drives the qrst_req/qsync_req level handshake, watches
// ack/start to detect completion and returns a one-cycle done pulse.
// Optional watchdog/abort path enabled by defining QRST_ARB_TIMEOUT_EN.
module qrst_arbiter
  import qrst_arb_pkg::*;
#(
  parameter int unsigned       NREQ     = 4,
  parameter int unsigned       TOUT_W   = 16,
  parameter logic [TOUT_W-1:0] TOUT_CYC = 16'd4000
) (
  input  logic                    t_clk_i,
  input  logic                    t_rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         req_sync_i,
  output logic [NREQ-1:0]         done_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] grant_id_o,
  output logic                    qrst_req_o,
  output logic                    qsync_req_o,
  input  logic                    qrst_ack_i,
  input  logic                    qproc_start_i
);

  localparam int unsigned IdW = $clog2(NREQ);

  state_e         state_q;
  logic [IdW-1:0] id_q;
  logic           type_q;
  logic           req_on_q;
  logic           exec_seen_q;
  logic [NREQ-1:0] done_q;
  logic           busy_q;

  logic           gnt_valid;
  logic [IdW-1:0] gnt_id;
  logic           grant_load;
  logic           run_done;

  // Never grant while the engine still holds ack from a previous command.
  assign grant_load = (state_q == StIdle) && !qrst_ack_i && gnt_valid;

  // Execution finished once start has been seen and has fallen; an early ack
  // drop is also treated as completion.
  assign run_done = !qrst_ack_i || (exec_seen_q && !qproc_start_i);

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk_i      (t_clk_i),
    .rst_ni     (t_rst_ni),
    .req_i      (req_i),
    .load_i     (grant_load),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

`ifdef QRST_ARB_TIMEOUT_EN
  logic [TOUT_W-1:0] tout_q;
  logic              tout_hit;
  logic              wd_leave;
  logic              err_q;

  assign tout_hit = is_engine_wait(state_q) && (tout_q == TOUT_CYC - 1'b1);
  assign wd_leave = ((state_q == StReq) && qrst_ack_i) ||
                    ((state_q == StRun) && run_done)   ||
                    ((state_q == StRel) && !qrst_ack_i) ||
                    tout_hit;

  // Watchdog: counts cycles spent in an engine-wait state, clears on any change.
  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      tout_q <= '0;
    end else if (is_engine_wait(state_q) && !wd_leave) begin
      tout_q <= tout_q + 1'b1;
    end else begin
      tout_q <= '0;
    end
  end

  assign err_o = err_q;
`else
  logic unused_tout;
  assign unused_tout = ^{TOUT_CYC, TOUT_W[0]};
  assign err_o       = 1'b0;
`endif

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      state_q     <= StIdle;
      id_q        <= '0;
      type_q      <= TYPE_QRST;
      req_on_q    <= 1'b0;
      exec_seen_q <= 1'b0;
      done_q      <= '0;
      busy_q      <= 1'b0;
`ifdef QRST_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef QRST_ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (grant_load) begin
            state_q  <= StReq;
            id_q     <= gnt_id;
            type_q   <= req_sync_i[gnt_id];
            req_on_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StReq: begin
          exec_seen_q <= 1'b0;
          if (qrst_ack_i) begin
            state_q <= StRun;
          end
`ifdef QRST_ARB_TIMEOUT_EN
          else if (tout_hit) begin
            state_q  <= StErr;
            req_on_q <= 1'b0;
            err_q    <= 1'b1;
          end
`endif
        end
        StRun: begin
          if (qproc_start_i) begin
            exec_seen_q <= 1'b1;
          end
          if (run_done) begin
            state_q  <= StRel;
            req_on_q <= 1'b0;
          end
`ifdef QRST_ARB_TIMEOUT_EN
          else if (tout_hit) begin
            state_q  <= StErr;
            req_on_q <= 1'b0;
            err_q    <= 1'b1;
          end
`endif
        end
        StRel: begin
          if (!qrst_ack_i) begin
            state_q      <= StDone;
            done_q[id_q] <= 1'b1;
          end
`ifdef QRST_ARB_TIMEOUT_EN
          else if (tout_hit) begin
            state_q      <= StDone;
            done_q[id_q] <= 1'b1;
            err_q        <= 1'b1;
          end
`endif
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
`ifdef QRST_ARB_TIMEOUT_EN
        StErr: begin
          if (!qrst_ack_i) begin
            state_q      <= StDone;
            done_q[id_q] <= 1'b1;
          end
        end
`endif
        default: begin
          state_q  <= StIdle;
          req_on_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = id_q;
  assign qrst_req_o  = req_on_q && (type_q == TYPE_QRST);
  assign qsync_req_o = req_on_q && (type_q == TYPE_QSYNC);

endmodule

// File: tb/tb_qrst_arbiter.sv
// Self-checking bench for qrst_arbiter: directed scenarios followed by a
// randomized phase scored against a round-robin reference model and a
// behavioural engine. Covers the abort path when QRST_ARB_TIMEOUT_EN is set.
module tb_qrst_arbiter;

  localparam int N = 4;

  logic         t_clk = 1'b0;
  logic         t_rst_ni = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_sync = '0;
  logic [N-1:0] done;
  logic         err;
  logic         busy;
  logic [1:0]   grant_id;
  logic         qrst_req;
  logic         qsync_req;
  logic         qrst_ack = 1'b0;
  logic         qproc_start = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int rr_ptr = 0;

  always #5 t_clk = ~t_clk;

  qrst_arbiter #(
    .NREQ    (N),
    .TOUT_W  (16),
    .TOUT_CYC(16'd20)
  ) dut (
    .t_clk_i      (t_clk),
    .t_rst_ni     (t_rst_ni),
    .req_i        (req),
    .req_sync_i   (req_sync),
    .done_o       (done),
    .err_o        (err),
    .busy_o       (busy),
    .grant_id_o   (grant_id),
    .qrst_req_o   (qrst_req),
    .qsync_req_o  (qsync_req),
    .qrst_ack_i   (qrst_ack),
    .qproc_start_i(qproc_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first pending requester at or after the pointer.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Engine model plus scoreboard for one granted transaction. Called at a
  // negedge with req already driven. start_len == 0 models an early ack drop.
  task automatic do_txn(input int exp_id, input bit exp_sync, input bit chk_lat,
                        input int ack_dly, input int start_len, input int rel_dly);
    int cnt;
    logic [1:0] exp_rq;
    exp_rq = exp_sync ? 2'b10 : 2'b01;
    cnt = 0;
    while (!(qrst_req || qsync_req) && cnt < 50) begin
      @(negedge t_clk);
      cnt++;
    end
    check("grant_seen", 32'(qrst_req || qsync_req), 1);
    if (!(qrst_req || qsync_req)) return;
    if (chk_lat) check("grant_latency", cnt, 1);
    check("grant_id", 32'(grant_id), exp_id);
    check("req_type", {qsync_req, qrst_req}, exp_rq);
    check("busy_grant", 32'(busy), 1);
    rr_ptr = (exp_id + 1) % N;
    repeat (ack_dly) begin
      @(negedge t_clk);
      check("req_hold_wait", {qsync_req, qrst_req}, exp_rq);
    end
    qrst_ack = 1'b1;
    @(negedge t_clk);
    check("req_hold_run", {qsync_req, qrst_req}, exp_rq);
    if (start_len == 0) begin
      qrst_ack = 1'b0;
      @(negedge t_clk);
      check("early_ack_release", {qsync_req, qrst_req}, 2'b00);
    end else begin
      qproc_start = 1'b1;
      repeat (start_len) begin
        @(negedge t_clk);
        check("no_early_release", {qsync_req, qrst_req}, exp_rq);
      end
      qproc_start = 1'b0;
      @(negedge t_clk);
      check("release", {qsync_req, qrst_req}, 2'b00);
      repeat (rel_dly) begin
        @(negedge t_clk);
        check("rel_wait_req", {qsync_req, qrst_req}, 2'b00);
        check("rel_wait_done", 32'(done), 0);
      end
      qrst_ack = 1'b0;
    end
    @(negedge t_clk);
    check("done_pulse", 32'(done), 32'(1) << exp_id);
    check("busy_done", 32'(busy), 1);
    req[exp_id] = 1'b0;
    @(negedge t_clk);
    check("done_clear", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
    check("err_quiet", 32'(err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge t_clk);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_reqs", {qsync_req, qrst_req}, 2'b00);
    t_rst_ni = 1'b1;
    @(negedge t_clk);
    check("idle_busy", 32'(busy), 0);

    // Plain QRST from requester 0.
    req = 4'b0001;
    req_sync = 4'b0000;
    do_txn(0, 1'b0, 1'b1, 2, 8, 1);

    // QSYNC from requester 2.
    req = 4'b0100;
    req_sync = 4'b0100;
    do_txn(2, 1'b1, 1'b1, 2, 8, 2);

    // Reset while the engine is running: everything drops at once.
    req = 4'b0010;
    req_sync = 4'b0000;
    @(negedge t_clk);
    check("wrap_grant", 32'(grant_id), 1);
    qrst_ack = 1'b1;
    @(negedge t_clk);
    qproc_start = 1'b1;
    @(negedge t_clk);
    #2 t_rst_ni = 1'b0;
    #1;
    check("arst_reqs", {qsync_req, qrst_req}, 2'b00);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_err", 32'(err), 0);
    check("arst_gid", 32'(grant_id), 0);
    qrst_ack = 1'b0;
    qproc_start = 1'b0;
    req = '0;
    @(negedge t_clk);
    t_rst_ni = 1'b1;
    rr_ptr = 0;
    @(negedge t_clk);
    check("post_rst_done", 32'(done), 0);

    // Round-robin with all four held; pointer restarts at 0.
    req = 4'b1111;
    do_txn(0, 1'b0, 1'b1, 1, 3, 0);
    do_txn(1, 1'b0, 1'b1, 1, 3, 0);
    do_txn(2, 1'b0, 1'b1, 1, 3, 0);
    do_txn(3, 1'b0, 1'b1, 1, 3, 0);
    req = 4'b1001;
    do_txn(0, 1'b0, 1'b1, 1, 2, 1);
    do_txn(3, 1'b0, 1'b1, 1, 2, 1);

    // Engine still acking in IDLE: no grant until ack is released.
    qrst_ack = 1'b1;
    req = 4'b0010;
    repeat (4) begin
      @(negedge t_clk);
      check("ack_busy_no_req", {qsync_req, qrst_req}, 2'b00);
      check("ack_busy_idle", 32'(busy), 0);
    end
    qrst_ack = 1'b0;
    do_txn(1, 1'b0, 1'b1, 2, 4, 1);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      int exp;
      for (int i = 0; i < N; i++) begin
        if (req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          req_sync[i] = 1'($urandom_range(0, 1));
        end
      end
      if (req == '0) begin
        int j;
        j = $urandom_range(0, N - 1);
        req[j] = 1'b1;
        req_sync[j] = 1'($urandom_range(0, 1));
      end
      exp = pick(req, rr_ptr);
      do_txn(exp, req_sync[exp], 1'b1, $urandom_range(0, 4), $urandom_range(0, 6),
             $urandom_range(0, 3));
    end
    req = '0;

`ifdef QRST_ARB_TIMEOUT_EN
    // Engine never acks: abort after TOUT_CYC cycles in REQ.
    req = 4'b0001;
    req_sync = 4'b0000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge t_clk);
      check("tout_wait_err", 32'(err), 0);
      check("tout_wait_req", {qsync_req, qrst_req}, 2'b01);
    end
    @(negedge t_clk);
    check("tout_err_pulse", 32'(err), 1);
    check("tout_req_low", {qsync_req, qrst_req}, 2'b00);
    @(negedge t_clk);
    check("tout_err_clear", 32'(err), 0);
    check("tout_done", 32'(done), 32'h1);
    req = '0;
    @(negedge t_clk);
    check("tout_idle", 32'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
